// File: rtl/mem_responder_pkg.sv
// Shared definitions for the mem_responder data-memory target: register offsets,
// control/status bit positions, the address-decode enum and a byte-lane merge helper.
package mem_resp_pkg;

  localparam logic [31:0] PERIPH_BASE_DEFAULT = 32'hFFFF_0000;

  // Word offsets inside the peripheral window (memaddr[4:2])
  localparam logic [2:0] TMR_LOAD   = 3'd0;
  localparam logic [2:0] TMR_COUNT  = 3'd1;
  localparam logic [2:0] TMR_CTRL   = 3'd2;
  localparam logic [2:0] TMR_STATUS = 3'd3;
  localparam logic [2:0] ERRCNT     = 3'd4;

  localparam int unsigned CTRL_EN     = 32'd0;
  localparam int unsigned CTRL_AUTO   = 32'd1;
  localparam int unsigned CTRL_IE     = 32'd2;
  localparam int unsigned STATUS_PEND = 32'd0;

  typedef enum logic [1:0] {
    RAM      = 2'd0,
    PERIPH   = 2'd1,
    UNMAPPED = 2'd2
  } decode_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_responder_irq_timer.sv
// irq_timer: down-counting timer with LOAD/COUNT/CTRL/STATUS registers and the
// active-low interrupt derived purely from registered PEND and IE.
module irq_timer
  import mem_resp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_i,
  input  logic [1:0]  off_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        nirq_o
);

  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        ie_q, ie_d;
  logic        pend_q, pend_d;
  logic        expire_s;
  logic        pend_clr_s;

  assign expire_s   = en_q && (count_q == 32'd0);
  assign pend_clr_s = wr_i && (off_i == TMR_STATUS[1:0]) && be_i[0] && wdata_i[STATUS_PEND];

  // Countdown step first; bus writes afterwards so they win for COUNT and EN
  always_comb begin
    load_d  = load_q;
    count_d = count_q;
    en_d    = en_q;
    auto_d  = auto_q;
    ie_d    = ie_q;
    if (en_q) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else if (auto_q) begin
        count_d = load_q;
      end else begin
        en_d = 1'b0;
      end
    end else begin
      count_d = count_q;
    end
    if (wr_i) begin
      case (off_i)
        TMR_LOAD[1:0]: begin
          load_d  = be_merge(load_q, wdata_i, be_i);
          count_d = load_d;
        end
        TMR_CTRL[1:0]: begin
          if (be_i[0]) begin
            en_d   = wdata_i[CTRL_EN];
            auto_d = wdata_i[CTRL_AUTO];
            ie_d   = wdata_i[CTRL_IE];
          end else begin
            ie_d = ie_q;
          end
        end
        default: load_d = load_q;
      endcase
    end else begin
      load_d = load_q;
    end
  end

  // Expiry sets PEND even when software clears it in the same cycle
  always_comb begin
    if (expire_s) begin
      pend_d = 1'b1;
    end else if (pend_clr_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Timer state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      load_q  <= 32'd0;
      count_q <= 32'd0;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      ie_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      load_q  <= load_d;
      count_q <= count_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
      ie_q    <= ie_d;
      pend_q  <= pend_d;
    end
  end

  // Register read mux
  always_comb begin
    rdata_o = 32'd0;
    case (off_i)
      TMR_LOAD[1:0]:   rdata_o = load_q;
      TMR_COUNT[1:0]:  rdata_o = count_q;
      TMR_CTRL[1:0]: begin
        rdata_o[CTRL_EN]   = en_q;
        rdata_o[CTRL_AUTO] = auto_q;
        rdata_o[CTRL_IE]   = ie_q;
      end
      TMR_STATUS[1:0]: rdata_o[STATUS_PEND] = pend_q;
      default:         rdata_o = 32'd0;
    endcase
  end

  assign nirq_o = ~(pend_q & ie_q);

endmodule

// File: rtl/mem_responder.sv
// mem_responder: zero-wait-state data RAM plus memory-mapped irq_timer.
// Optional MEM_RESP_ERRCNT_EN adds a saturating unmapped-access counter at PERIPH_BASE+0x10.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 32'd1024,
  parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memaddr,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  be,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        nIRQ
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];
  decode_e       dec_s;
  logic [AW-1:0] idx_s;
  logic          ram_hit_s;
  logic          periph_hit_s;
  logic [2:0]    off_s;
  logic          tmr_wr_s;
  logic [31:0]   tmr_rdata_s;
  logic          unused_addr_s;

  assign unused_addr_s = ^memaddr[1:0];
  assign idx_s         = memaddr[AW+1:2];
  assign ram_hit_s     = (memaddr < 32'(DEPTH_WORDS * 32'd4));

`ifdef MEM_RESP_ERRCNT_EN
  assign periph_hit_s = (memaddr[31:5] == PERIPH_BASE[31:5]);
  assign off_s        = memaddr[4:2];
`else
  assign periph_hit_s = (memaddr[31:4] == PERIPH_BASE[31:4]);
  assign off_s        = {1'b0, memaddr[3:2]};
`endif

  // Address decode
  always_comb begin
    if (ram_hit_s) begin
      dec_s = RAM;
    end else if (periph_hit_s) begin
      dec_s = PERIPH;
    end else begin
      dec_s = UNMAPPED;
    end
  end

  assign tmr_wr_s = memwrite && (dec_s == PERIPH) && !off_s[2];

  // RAM byte-lane writes; contents intentionally have no reset
  always_ff @(posedge clk) begin
    if (memwrite && (dec_s == RAM)) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[idx_s][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

  irq_timer u_timer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .wr_i    (tmr_wr_s),
    .off_i   (off_s[1:0]),
    .be_i    (be),
    .wdata_i (writedata),
    .rdata_o (tmr_rdata_s),
    .nirq_o  (nIRQ)
  );

`ifdef MEM_RESP_ERRCNT_EN
  logic [15:0] errcnt_q, errcnt_d;
  logic        err_clr_s;
  logic        err_evt_s;

  assign err_clr_s = memwrite && (dec_s == PERIPH) && (off_s == ERRCNT);
  assign err_evt_s = (memwrite || memread) && (dec_s == UNMAPPED);

  // Saturating unmapped-access counter, cleared by any write to it
  always_comb begin
    if (err_clr_s) begin
      errcnt_d = 16'd0;
    end else if (err_evt_s && (errcnt_q != 16'hFFFF)) begin
      errcnt_d = errcnt_q + 16'd1;
    end else begin
      errcnt_d = errcnt_q;
    end
  end

  // Error counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      errcnt_q <= 16'd0;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end
`endif

  // Combinational read mux; a read during a write sees the pre-edge word
  always_comb begin
    readdata = 32'd0;
    if (!memread) begin
      readdata = 32'd0;
    end else begin
      case (dec_s)
        RAM: readdata = mem_q[idx_s];
        PERIPH: begin
          if (!off_s[2]) begin
            readdata = tmr_rdata_s;
`ifdef MEM_RESP_ERRCNT_EN
          end else if (off_s == ERRCNT) begin
            readdata = {16'd0, errcnt_q};
`endif
          end else begin
            readdata = 32'd0;
          end
        end
        default: readdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed bus transactions, a bench-side
// reference model compared every cycle, and literal expectations for key scenarios.
module tb_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] memaddr = 32'd0;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [3:0]  be = 4'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        nIRQ;

  mem_responder #(.DEPTH_WORDS(DEPTH), .PERIPH_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .memaddr(memaddr), .memwrite(memwrite),
    .memread(memread), .be(be), .writedata(writedata),
    .readdata(readdata), .nIRQ(nIRQ)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ram [DEPTH];
  bit          m_valid [DEPTH];
  logic [31:0] m_load, m_cnt;
  bit          m_en, m_auto, m_ie, m_pend;
  int unsigned m_err;

  function automatic bit is_ram(input logic [31:0] a);
    return a < DEPTH * 4;
  endfunction

  function automatic bit is_periph(input logic [31:0] a);
`ifdef MEM_RESP_ERRCNT_EN
    return a[31:5] == BASE[31:5];
`else
    return a[31:4] == BASE[31:4];
`endif
  endfunction

  function automatic bit rd_known(input logic [31:0] a);
    return !(memread && is_ram(a) && !m_valid[a[11:2]]);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (!memread) return 32'd0;
    if (is_ram(a)) return m_ram[a[11:2]];
    if (is_periph(a)) begin
      case (a[4:2])
        3'd0: return m_load;
        3'd1: return m_cnt;
        3'd2: return {29'd0, m_ie, m_auto, m_en};
        3'd3: return {31'd0, m_pend};
`ifdef MEM_RESP_ERRCNT_EN
        3'd4: return {16'd0, m_err[15:0]};
`endif
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_load = 32'd0; m_cnt = 32'd0;
    m_en = 1'b0; m_auto = 1'b0; m_ie = 1'b0; m_pend = 1'b0;
    m_err = 0;
  endtask

  task automatic model_edge();
    logic [31:0] a, n_load, n_cnt;
    bit n_en, n_auto, n_ie, n_pend, expire;
    int unsigned n_err;
    a = memaddr;
    n_load = m_load; n_cnt = m_cnt; n_en = m_en; n_auto = m_auto; n_ie = m_ie;
    n_pend = m_pend; n_err = m_err;
    expire = m_en && (m_cnt == 32'd0);
    if (m_en) begin
      if (m_cnt != 32'd0) n_cnt = m_cnt - 32'd1;
      else if (m_auto) n_cnt = m_load;
      else n_en = 1'b0;
    end
    if (memwrite && is_ram(a)) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) m_ram[a[11:2]][8*i +: 8] = writedata[8*i +: 8];
      if (be == 4'hF) m_valid[a[11:2]] = 1'b1;
    end else if (memwrite && is_periph(a)) begin
      case (a[4:2])
        3'd0: begin
          for (int i = 0; i < 4; i++)
            if (be[i]) n_load[8*i +: 8] = writedata[8*i +: 8];
          n_cnt = n_load;
        end
        3'd2: if (be[0]) begin
          n_en = writedata[0]; n_auto = writedata[1]; n_ie = writedata[2];
        end
        3'd3: if (be[0] && writedata[0]) n_pend = 1'b0;
`ifdef MEM_RESP_ERRCNT_EN
        3'd4: n_err = 0;
`endif
        default: ;
      endcase
    end
    if (expire) n_pend = 1'b1;
`ifdef MEM_RESP_ERRCNT_EN
    if ((memwrite || memread) && !is_ram(a) && !is_periph(a) && m_err < 32'hFFFF)
      n_err = m_err + 1;
`endif
    m_load = n_load; m_cnt = n_cnt; m_en = n_en; m_auto = n_auto; m_ie = n_ie;
    m_pend = n_pend; m_err = n_err;
  endtask

  always @(posedge clk) if (reset) model_edge();
  always @(negedge reset) model_reset();

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (reset) begin
      chk("nIRQ_model", {31'd0, nIRQ}, {31'd0, ~(m_pend & m_ie)});
      if (rd_known(memaddr)) chk("readdata_model", readdata, exp_rd(memaddr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    memaddr = a; writedata = d; be = b; memwrite = 1'b1; memread = 1'b1;
    cyc();
    memwrite = 1'b0; memread = 1'b0; be = 4'd0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    memaddr = a; memread = 1'b1;
    #1;
    chk(name, readdata, exp);
    memread = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    rd("rst_load", BASE + 32'h0, 32'd0);
    rd("rst_count", BASE + 32'h4, 32'd0);
    rd("rst_ctrl", BASE + 32'h8, 32'd0);
    chk("rst_nirq", {31'd0, nIRQ}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    cyc();

    // RAM byte enables and bounds
    wr(32'h40, 32'h1122_3344, 4'hF);
    wr(32'h40, 32'hAABB_CCDD, 4'b0101);
    rd("ram_be", 32'h40, 32'h11BB_33DD);
    wr(32'h0, 32'h0102_0304, 4'hF);
    wr(32'h1000, 32'hFFFF_FFFF, 4'hF);
    rd("ram_bound", 32'h0, 32'h0102_0304);
    wr(32'hFFC, 32'hCAFE_F00D, 4'hF);
    rd("ram_last", 32'hFFC, 32'hCAFE_F00D);

    // Unmapped and memread gating
    rd("unmapped_rd", 32'h8000_0000, 32'd0);
    wr(32'h8000_0000, 32'hDEAD_BEEF, 4'hF);
    rd("ram_after_unmapped", 32'h40, 32'h11BB_33DD);
    memaddr = 32'h40; memread = 1'b0; #1;
    chk("memread_low", readdata, 32'd0);

    // One-shot timer
    wr(BASE + 32'h0, 32'd3, 4'hF);
    wr(BASE + 32'h8, 32'd5, 4'hF);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("oneshot_wait", {31'd0, nIRQ}, 32'd1);
    end
    cyc();
    chk("oneshot_irq", {31'd0, nIRQ}, 32'd0);
    rd("oneshot_ctrl", BASE + 32'h8, 32'd4);
    rd("oneshot_count", BASE + 32'h4, 32'd0);
    wr(BASE + 32'h4, 32'd77, 4'hF);
    rd("count_ro", BASE + 32'h4, 32'd0);
    wr(BASE + 32'hC, 32'd1, 4'hF);
    chk("status_clr", {31'd0, nIRQ}, 32'd1);

    // Auto-reload, clear colliding with expiry, LOAD write during countdown
    wr(BASE + 32'h0, 32'd2, 4'hF);
    wr(BASE + 32'h8, 32'd7, 4'hF);
    cyc(); cyc();
    wr(BASE + 32'hC, 32'd1, 4'hF);
    chk("auto_set_wins", {31'd0, nIRQ}, 32'd0);
    wr(BASE + 32'hC, 32'd1, 4'hF);
    chk("auto_cleared", {31'd0, nIRQ}, 32'd1);
    cyc();
    chk("auto_mid", {31'd0, nIRQ}, 32'd1);
    cyc();
    chk("auto_period", {31'd0, nIRQ}, 32'd0);
    wr(BASE + 32'h0, 32'd9, 4'hF);
    rd("load_wins", BASE + 32'h4, 32'd9);
    wr(BASE + 32'h8, 32'd0, 4'hF);
    wr(BASE + 32'hC, 32'd1, 4'hF);

    // CTRL write clearing EN in the expiry cycle
    wr(BASE + 32'h0, 32'd1, 4'hF);
    wr(BASE + 32'h8, 32'd5, 4'hF);
    cyc();
    wr(BASE + 32'h8, 32'd4, 4'hF);
    chk("ctrl_expiry_pend", {31'd0, nIRQ}, 32'd0);
    rd("ctrl_expiry_ctrl", BASE + 32'h8, 32'd4);
    wr(BASE + 32'hC, 32'd1, 4'hF);

    // Asynchronous reset mid-count
    wr(BASE + 32'h0, 32'd100, 4'hF);
    wr(BASE + 32'h8, 32'd5, 4'hF);
    memaddr = BASE + 32'h4; memread = 1'b1;
    repeat (43) cyc();
    chk("count_57", readdata, 32'd57);
    #3 reset = 1'b0;
    #1 chk("async_count", readdata, 32'd0);
    chk("async_nirq", {31'd0, nIRQ}, 32'd1);
    memaddr = BASE + 32'h8;
    #1 chk("async_ctrl", readdata, 32'd0);
    memaddr = BASE + 32'hC;
    #1 chk("async_status", readdata, 32'd0);
    memread = 1'b0;
    #1 reset = 1'b1;
    cyc();
    rd("ram_survives_reset", 32'h40, 32'h11BB_33DD);

    // Error counter (or its absence)
    wr(32'h8000_0000, 32'd1, 4'hF);
    wr(32'h8000_0004, 32'd2, 4'hF);
    wr(32'h8000_0008, 32'd3, 4'hF);
`ifdef MEM_RESP_ERRCNT_EN
    rd("errcnt", BASE + 32'h10, 32'd3);
`else
    rd("errcnt_absent", BASE + 32'h10, 32'd0);
`endif
    wr(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    rd("errcnt_clr", BASE + 32'h10, 32'd0);
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
